// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch-prediction update path:
//   IDX_W         - direction-table / BTB index width (index = pc[IDX_W+1:2])
//   TBL_SIZE      - number of direction counters
//   btb_upd_t     - one queued BTB write {idx, target}
//   SNT/WNT/WT/ST - 2-bit saturating counter encodings
//   drain_state_e - BTB write-drain FSM states
//   ctr_train()   - saturating counter update
// ---------------------------------------------------------------------------
package bp_pkg;

    localparam int IDX_W    = 8;
    localparam int TBL_SIZE = 1 << IDX_W;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [31:0]      target;
    } btb_upd_t;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    typedef enum logic {
        DRAIN_IDLE  = 1'b0,
        DRAIN_WRITE = 1'b1
    } drain_state_e;

    function automatic logic [1:0] ctr_train(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == ST) ? ST : ctr + 2'd1;
        end else begin
            nxt = (ctr == SNT) ? SNT : ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// ---------------------------------------------------------------------------
// bp_upd_fifo
// Synchronous FIFO of btb_upd_t entries. Pointers are log2(DEPTH) bits and
// wrap naturally; a separate count disambiguates full from empty.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   push_i, din_i   - write request and data (ignored when full)
//   pop_i           - read request (ignored when empty); dout_o is the head
//   full_o, empty_o - status, derived from the registered count
//   count_o         - number of stored entries
// ---------------------------------------------------------------------------
module bp_upd_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push_i,
    input  btb_upd_t       din_i,
    input  logic           pop_i,
    output btb_upd_t       dout_o,
    output logic           full_o,
    output logic           empty_o,
    output logic [PTR_W:0] count_o
);

    btb_upd_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Push and pop together leave the count unchanged.
        if (push_ok && !pop_ok) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= din_i;
            end
        end
    end

endmodule

// File: rtl/branch_update_unit.sv
// ---------------------------------------------------------------------------
// branch_update_unit
// Takes resolved branches from execute, trains a table of 2-bit saturating
// direction counters, raises a registered redirect on mispredict and queues
// BTB target writes that a small FSM drains through a valid/ready port.
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   ex_valid/ex_ready           - resolved-branch handshake
//   ex_pc, ex_taken, ex_target  - actual outcome
//   ex_pred_taken/_target       - what fetch predicted
//   redirect_valid/redirect_pc  - one-cycle redirect, the cycle after accept
//   btb_wr_en/btb_wr_ready      - BTB write handshake
//   btb_wr_idx/btb_wr_target    - BTB write payload (head of queue)
//   fetch_pc/fetch_pred_taken   - combinational direction lookup
//   dbg_drain_state_o           - drain FSM state (0 idle, 1 write)
//
// Handshakes: a transfer happens on a cycle where valid && ready. Once valid
// is raised the payload is held stable until that cycle. ex_ready depends
// only on registered queue occupancy; btb_wr_idx/target stay stable while
// btb_wr_en is high and btb_wr_ready is low.
// ---------------------------------------------------------------------------
module branch_update_unit
    import bp_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_target,
    output logic             ex_ready,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             btb_wr_en,
    input  logic             btb_wr_ready,
    output logic [IDX_W-1:0] btb_wr_idx,
    output logic [31:0]      btb_wr_target,
    input  logic [31:0]      fetch_pc,
    output logic             fetch_pred_taken,
    output logic             dbg_drain_state_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]       ctr_q [TBL_SIZE];
    logic [IDX_W-1:0] ex_idx, fetch_idx;
    logic             accept, mispredict, push, pop;
    logic             redirect_valid_q, redirect_valid_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    drain_state_e     state_q, state_d;
    btb_upd_t         push_entry, head;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             unused_fetch_bits;

    assign ex_idx    = ex_pc[IDX_W+1:2];
    assign fetch_idx = fetch_pc[IDX_W+1:2];
    assign unused_fetch_bits = ^{fetch_pc[31:IDX_W+2], fetch_pc[1:0]};

    assign ex_ready   = !fifo_full;
    assign accept     = ex_valid && ex_ready;
    assign mispredict = (ex_taken != ex_pred_taken) ||
                        (ex_taken && (ex_target != ex_pred_target));
    // Only taken branches with a new target need a BTB write.
    assign push       = accept && ex_taken && (ex_target != ex_pred_target);
    assign pop        = (state_q == DRAIN_WRITE) && btb_wr_ready && !fifo_empty;

    assign push_entry.idx    = ex_idx;
    assign push_entry.target = ex_target;

    bp_upd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (push_entry),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Fetch reads the registered counter, so a same-cycle update at the same
    // index is seen only from the next cycle.
    assign fetch_pred_taken = ctr_q[fetch_idx][1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TBL_SIZE; i++) begin
                ctr_q[i] <= WNT;
            end
        end else if (accept) begin
            ctr_q[ex_idx] <= ctr_train(ctr_q[ex_idx], ex_taken);
        end
    end

    assign redirect_valid_d = accept && mispredict;
    assign redirect_pc_d    = ex_taken ? ex_target : ex_pc + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            if (redirect_valid_d) begin
                redirect_pc_q <= redirect_pc_d;
            end
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DRAIN_IDLE: begin
                if (push) begin
                    state_d = DRAIN_WRITE;
                end
            end
            DRAIN_WRITE: begin
                // Last entry leaving with nothing arriving behind it.
                if (pop && (fifo_count == CNT_W'(1)) && !push) begin
                    state_d = DRAIN_IDLE;
                end
            end
            default: state_d = DRAIN_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DRAIN_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign btb_wr_en         = (state_q == DRAIN_WRITE);
    assign btb_wr_idx        = btb_wr_en ? head.idx : '0;
    assign btb_wr_target     = btb_wr_en ? head.target : '0;
    assign dbg_drain_state_o = state_q;

endmodule

// File: tb/tb_branch_update_unit.sv
module tb_branch_update_unit;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        ex_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        btb_wr_en;
    logic        btb_wr_ready;
    logic [7:0]  btb_wr_idx;
    logic [31:0] btb_wr_target;
    logic [31:0] fetch_pc;
    logic        fetch_pred_taken;
    logic        dbg_drain_state_o;

    int total = 0;
    int bad   = 0;

    // Reference model: counters as plain integers, BTB queue as {idx,target}.
    int          m_ctr [256];
    logic [39:0] exp_q [$];
    logic        m_rv;
    logic [31:0] m_rpc;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic        pred_taken;
        logic [31:0] pred_target;
        logic        rv;
        logic [31:0] rpc;
        logic        push;
        logic        fetch;
    } vec_t;

    vec_t vecs [10];

    branch_update_unit #(.FIFO_DEPTH(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .ex_valid          (ex_valid),
        .ex_pc             (ex_pc),
        .ex_taken          (ex_taken),
        .ex_target         (ex_target),
        .ex_pred_taken     (ex_pred_taken),
        .ex_pred_target    (ex_pred_target),
        .ex_ready          (ex_ready),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .btb_wr_en         (btb_wr_en),
        .btb_wr_ready      (btb_wr_ready),
        .btb_wr_idx        (btb_wr_idx),
        .btb_wr_target     (btb_wr_target),
        .fetch_pc          (fetch_pc),
        .fetch_pred_taken  (fetch_pred_taken),
        .dbg_drain_state_o (dbg_drain_state_o)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_ctr[i] = 1;
        exp_q.delete();
        m_rv  = 1'b0;
        m_rpc = '0;
    endtask

    task automatic set_rec(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                           input logic ptk, input logic [31:0] ptg);
        ex_pc          = pc;
        ex_taken       = tk;
        ex_target      = tg;
        ex_pred_taken  = ptk;
        ex_pred_target = ptg;
    endtask

    // One clock cycle with the currently driven inputs. Checks combinational
    // outputs against the model, advances the model, then checks the redirect.
    task automatic step(output logic acc);
        logic        pop;
        logic        misp;
        logic [7:0]  idx;
        int          c;
        #1;
        chk("ex_ready", ex_ready, exp_q.size() < 4);
        chk("fetch_pred", fetch_pred_taken, m_ctr[fetch_pc[9:2]] >= 2);
        chk("wr_en", btb_wr_en, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            chk("wr_idx", btb_wr_idx, exp_q[0][39:32]);
            chk("wr_target", btb_wr_target, exp_q[0][31:0]);
        end
        acc = ex_valid && (exp_q.size() < 4);
        pop = (exp_q.size() != 0) && btb_wr_ready;
        if (pop) void'(exp_q.pop_front());
        m_rv = 1'b0;
        if (acc) begin
            idx = ex_pc[9:2];
            c = m_ctr[idx];
            if (ex_taken) c = (c < 3) ? c + 1 : 3;
            else          c = (c > 0) ? c - 1 : 0;
            m_ctr[idx] = c;
            misp = (ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target);
            if (misp) begin
                m_rv  = 1'b1;
                m_rpc = ex_taken ? ex_target : ex_pc + 32'd4;
            end
            if (ex_taken && ex_target != ex_pred_target) exp_q.push_back({idx, ex_target});
        end
        @(posedge clk);
        #1;
        chk("redirect_valid", redirect_valid, m_rv);
        if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic        acc;
        logic        held;
        int          waited;

        vecs[0] = '{32'h40,       1'b0, 32'h0,    1'b1, 32'h0,    1'b1, 32'h44,   1'b0, 1'b1};
        vecs[1] = '{32'h40,       1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0};
        vecs[2] = '{32'h40,       1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0};
        vecs[3] = '{32'h40,       1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0};
        vecs[4] = '{32'h40,       1'b1, 32'h80,   1'b1, 32'h80,   1'b0, 32'h0,    1'b0, 1'b0};
        vecs[5] = '{32'h40,       1'b1, 32'h80,   1'b1, 32'h80,   1'b0, 32'h0,    1'b0, 1'b1};
        vecs[6] = '{32'hFFFFFFFC, 1'b0, 32'h0,    1'b1, 32'h0,    1'b1, 32'h0,    1'b0, 1'b0};
        vecs[7] = '{32'h1000,     1'b1, 32'h2000, 1'b1, 32'h3000, 1'b1, 32'h2000, 1'b1, 1'b1};
        vecs[8] = '{32'h8,        1'b1, 32'h10,   1'b0, 32'h10,   1'b1, 32'h10,   1'b0, 1'b1};
        vecs[9] = '{32'h20,       1'b0, 32'h999,  1'b0, 32'h5,    1'b0, 32'h0,    1'b0, 1'b0};

        rst = 1'b1;
        ex_valid = 1'b0;
        set_rec(32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        btb_wr_ready = 1'b1;
        fetch_pc = 32'h100;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        #1;
        chk("rst_fetch_pred", fetch_pred_taken, 1'b0);
        chk("rst_ex_ready", ex_ready, 1'b1);
        chk("rst_wr_en", btb_wr_en, 1'b0);
        chk("rst_wr_idx", btb_wr_idx, 8'h00);
        chk("rst_wr_target", btb_wr_target, 32'h0);
        chk("rst_redirect_valid", redirect_valid, 1'b0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        chk("rst_state", dbg_drain_state_o, 1'b0);

        // Training at pc 0x40: three back-to-back mispredicted taken records
        fetch_pc = 32'h40;
        #1 chk("train_pre_fetch", fetch_pred_taken, 1'b0);
        for (int i = 0; i < 3; i++) begin
            set_rec(32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
            ex_valid = 1'b1;
            step(acc);
            chk("train_fetch", fetch_pred_taken, 1'b1);
            chk("train_rv", redirect_valid, 1'b1);
            chk("train_rpc", redirect_pc, 32'h80);
            chk("train_wr_en", btb_wr_en, 1'b1);
            chk("train_wr_idx", btb_wr_idx, 8'h10);
            chk("train_wr_tgt", btb_wr_target, 32'h80);
        end
        ex_valid = 1'b0;
        step(acc);
        chk("train_rv_drop", redirect_valid, 1'b0);

        // Table-driven single records, each followed by an idle cycle
        for (int v = 0; v < 10; v++) begin
            set_rec(vecs[v].pc, vecs[v].taken, vecs[v].target, vecs[v].pred_taken, vecs[v].pred_target);
            fetch_pc = vecs[v].pc;
            ex_valid = 1'b1;
            step(acc);
            chk("vec_rv", redirect_valid, vecs[v].rv);
            if (vecs[v].rv) chk("vec_rpc", redirect_pc, vecs[v].rpc);
            chk("vec_push", btb_wr_en, vecs[v].push);
            if (vecs[v].push) chk("vec_wr_tgt", btb_wr_target, vecs[v].target);
            chk("vec_fetch", fetch_pred_taken, vecs[v].fetch);
            ex_valid = 1'b0;
            step(acc);
        end

        // Backpressure: four fill the queue, the fifth is held
        btb_wr_ready = 1'b0;
        fetch_pc = 32'h100;
        for (int i = 0; i < 4; i++) begin
            set_rec(32'h100 + 32'(i * 4), 1'b1, 32'h500 + 32'(i * 16), 1'b1, 32'h0);
            ex_valid = 1'b1;
            waited = 0;
            acc = 1'b0;
            while (!acc && waited < 10) begin
                step(acc);
                waited++;
            end
            chk("bp_accept_bound", acc, 1'b1);
        end
        chk("bp_full", ex_ready, 1'b0);
        set_rec(32'h110, 1'b1, 32'h540, 1'b1, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step(acc);
            chk("bp_held", ex_ready, 1'b0);
            chk("bp_stable_idx", btb_wr_idx, 8'h40);
            chk("bp_stable_tgt", btb_wr_target, 32'h500);
        end
        btb_wr_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k >= 2) ex_valid = 1'b0;
            #1;
            chk("bp_drain_en", btb_wr_en, 1'b1);
            chk("bp_drain_tgt", btb_wr_target, 32'h500 + 32'(k * 16));
            if (k == 0) chk("bp_still_full", ex_ready, 1'b0);
            if (k == 1) chk("bp_fifth_accept", ex_ready, 1'b1);
            step(acc);
        end
        chk("bp_drained", btb_wr_en, 1'b0);

        // Simultaneous push and pop with two queued, across the pointer wrap
        btb_wr_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (k < 5) begin
                set_rec(32'h200 + 32'(k * 4), 1'b1, 32'h700 + 32'(k * 16), 1'b1, 32'h0);
                ex_valid = 1'b1;
            end else begin
                ex_valid = 1'b0;
            end
            if (k >= 2) begin
                btb_wr_ready = 1'b1;
                #1;
                chk("pp_head_tgt", btb_wr_target, 32'h700 + 32'((k - 2) * 16));
                chk("pp_head_idx", btb_wr_idx, 8'h80 + 8'(k - 2));
                chk("pp_ready", ex_ready, 1'b1);
            end
            step(acc);
        end
        chk("pp_empty", btb_wr_en, 1'b0);

        // Reset mid-drain
        btb_wr_ready = 1'b0;
        fetch_pc = 32'h40;
        for (int k = 0; k < 2; k++) begin
            set_rec(32'h300 + 32'(k * 4), 1'b1, 32'h900, 1'b1, 32'h0);
            ex_valid = 1'b1;
            step(acc);
        end
        ex_valid = 1'b0;
        chk("mid_en_before", btb_wr_en, 1'b1);
        chk("mid_fetch_before", fetch_pred_taken, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mid_en_async", btb_wr_en, 1'b0);
        chk("mid_ready_async", ex_ready, 1'b1);
        chk("mid_fetch_async", fetch_pred_taken, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        btb_wr_ready = 1'b1;
        step(acc);
        chk("mid_en_after", btb_wr_en, 1'b0);
        chk("mid_rv_after", redirect_valid, 1'b0);

        // Randomized traffic against the model
        held = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!held) begin
                set_rec(32'h1000 + 32'($urandom_range(0, 7) * 4),
                        1'($urandom_range(0, 1)),
                        32'h2000 + 32'($urandom_range(0, 3) * 4),
                        1'($urandom_range(0, 1)),
                        32'h2000 + 32'($urandom_range(0, 3) * 4));
                ex_valid = 1'($urandom_range(0, 1));
            end
            btb_wr_ready = ($urandom_range(0, 3) != 0);
            fetch_pc = 32'h1000 + 32'($urandom_range(0, 7) * 4);
            step(acc);
            held = ex_valid && !acc;
        end
        ex_valid = 1'b0;
        btb_wr_ready = 1'b1;
        repeat (6) step(acc);
        chk("final_empty", btb_wr_en, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_update_unit.md
# branch_update_unit

Resolution-side companion to the branch target buffer. It accepts resolved branches from the execute stage and detects mispredictions, issuing a registered redirect. It trains an internal 256-entry table of 2-bit saturating direction counters and queues BTB target writes in a 4-entry FIFO, draining them through a ready/valid write port. Fetch reads the direction prediction combinationally from this block and the target from the BTB.

## Interface
- `FIFO_DEPTH`, 4: update-queue entries (power of two).
- `IDX_W`, 8: table index width. Index = `pc[IDX_W+1:2]`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous and active-high; clears all state.
- `ex_valid`  in  1  resolved-branch record present this cycle.
- `ex_pc`  in  32  PC of resolved branch.
- `ex_taken`  in  1  actual direction.
- `ex_target`  in  32  actual taken target.
- `ex_pred_taken`  in  1  direction predicted at fetch.
- `ex_pred_target`  in  32  target predicted at fetch.
- `ex_ready`  out  1  low when FIFO full; `ex_valid` must be held until accepted.
- `redirect_valid`  out  1  one-cycle pulse on mispredict.
- `redirect_pc`  out  32  correct next PC.
- `btb_wr_en`  out  1  BTB write request (valid).
- `btb_wr_ready`  in  1  BTB accepts write this cycle.
- `btb_wr_idx`  out  IDX_W  BTB index.
- `btb_wr_target`  out  32  target to store.
- `fetch_pc`  in  32  fetch-stage PC.
- `fetch_pred_taken`  out  1  MSB of counter at `fetch_pc` index, combinational.

## Operation
- Accept: `ex_valid && ex_ready`.
- Counter update on accept: taken → saturating +1 (max 3), not taken → saturating −1 (min 0). Applied in the same cycle as the accept.
- Mispredict on accept is defined as `ex_taken != ex_pred_taken`, or `ex_taken && ex_target != ex_pred_target`.
- On mispredict, the next cycle has `redirect_valid`=1. `redirect_pc` = `ex_target` if taken, else `ex_pc+4` (32-bit wrap).
- BTB push: on accept with `ex_taken`=1 and `ex_target != ex_pred_target`, push {idx, ex_target}. Not-taken branches never write the BTB.
- Drain FSM states:
  - IDLE: FIFO empty, `btb_wr_en`=0; goes to WRITE when a push occurs.
  - WRITE: `btb_wr_en`=1 presenting the head entry. Head pops on `btb_wr_ready`. Returns to IDLE when the pop empties the FIFO with no same-cycle push.
- `btb_wr_idx` and `btb_wr_target` are stable while `btb_wr_en`=1 and `btb_wr_ready`=0.
- Full: `ex_ready`=0 when count == FIFO_DEPTH. A pop and push in the same cycle while full is not allowed; `ex_ready` depends only on registered count.
- Simultaneous push and pop: count unchanged, order preserved.
- Wrap-around: read and write pointers are `log2(FIFO_DEPTH)` bits and wrap naturally.
- Fetch/update same index in the same cycle: fetch sees the pre-update counter value.

## Timing
- Reset values:
  - counters = 1 (weakly not-taken), so `fetch_pred_taken`=0;
  - FIFO empty, FSM IDLE;
  - `btb_wr_en`=0, `btb_wr_idx`=0, `btb_wr_target`=0;
  - `redirect_valid`=0, `redirect_pc`=0;
  - `ex_ready`=1.
- Reset asserted mid-drain aborts the pending write immediately; the queued entries are lost.
- Latency:
  - redirect: 1 cycle after accept;
  - earliest BTB write: the cycle after accept (entry registered);
  - counter visible to fetch: the cycle after accept.
- `redirect_valid` is exactly one cycle per mispredicted branch, including back-to-back mispredicts.

## Structure
- Shared package `bp_pkg` holds:
  - `IDX_W`;
  - `typedef struct packed {logic [IDX_W-1:0] idx; logic [31:0] target;} btb_upd_t`;
  - counter encoding constants `SNT=0, WNT=1, WT=2, ST=3`;
  - drain-FSM enum.
- Sub-module `bp_upd_fifo`: a parameterized synchronous FIFO of `btb_upd_t` with full/empty/count outputs.
- Counter array and FSM live in the top.

## Test plan
- Reset, then `fetch_pc`=0x100: `fetch_pred_taken`=0. All outputs at reset values. `ex_ready`=1.
- Train: three accepted taken records at pc=0x40, target=0x80, pred target 0x0:
  - counter at idx 0x10 goes 1→2→3→3;
  - `fetch_pred_taken`=1 from the cycle after the first accept;
  - each record redirects to 0x80 or enqueues per the rules.
- Mispredict not-taken: pc=0xFFFFFFFC, pred_taken=1, taken=0 → `redirect_pc`=0x00000000 (wrap) with `redirect_valid` for exactly one cycle. No BTB push.
- Backpressure: hold `btb_wr_ready`=0 and push 5 target-changing taken branches.
  - `ex_ready` drops after the 4th accept; the 5th is held.
  - Releasing `btb_wr_ready` drains the entries in order, at one per cycle, with stable outputs while stalled.
- Simultaneous push and pop with 2 entries queued: count stays 2 and FIFO order is preserved across the pointer wrap.
- Assert `rst` while `btb_wr_en`=1: `btb_wr_en` drops asynchronously, the FIFO empties, and counters return to 1.
